// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: single word-organised memory serving IM fetches and DM loads/stores, 1-cycle registered reads.
// Optional MEM_OOR_CHECK_EN: out-of-range accesses read 0, drop stores, and set sticky oor_err.
module cpu_mem_responder #(
   parameter int DEPTH = 16384
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IM_enable,
   input  logic [31:0] IM_address,
   output logic [31:0] IM_out,
   input  logic        DM_enable,
   input  logic        DM_write,
   input  logic [31:0] DM_address,
   input  logic [31:0] DM_in,
   output logic [31:0] DM_out,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic        oor_err
);
   localparam int AW = $clog2(DEPTH);

   // No handshake: the responder is always ready and every enabled request
   // completes at the edge that samples it, with data valid from then on.
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] im_idx;
   logic [AW-1:0] dm_idx;
   logic          dm_load;
   logic          dm_store;
   logic          im_oor;
   logic          dm_oor;
   logic          unused_addr;

   assign im_idx   = IM_address[AW+1:2];
   assign dm_idx   = DM_address[AW+1:2];
   assign dm_load  = DM_enable & ~DM_write;
   assign dm_store = DM_enable & DM_write;

`ifdef MEM_OOR_CHECK_EN
   assign im_oor      = |IM_address[31:AW+2];
   assign dm_oor      = |DM_address[31:AW+2];
   assign unused_addr = ^{IM_address[1:0], DM_address[1:0]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         oor_err <= 1'b0;
      end else if ((IM_enable && im_oor) || (DM_enable && dm_oor)) begin
         oor_err <= 1'b1;
      end
   end
`else
   assign im_oor      = 1'b0;
   assign dm_oor      = 1'b0;
   assign oor_err     = 1'b0;
   assign unused_addr = ^{IM_address[31:AW+2], IM_address[1:0],
                          DM_address[31:AW+2], DM_address[1:0]};
`endif

   // Reads use the pre-edge array, so an IM fetch colliding with a DM store sees the old word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         IM_out   <= '0;
         DM_out   <= '0;
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (IM_enable) begin
            IM_out <= im_oor ? 32'h0 : mem[im_idx];
         end
         if (DM_enable) begin
            DM_out <= DM_write ? DM_in : (dm_oor ? 32'h0 : mem[dm_idx]);
         end
         rd_count <= rd_count + 32'(IM_enable) + 32'(dm_load);
         wr_count <= wr_count + 32'(dm_store);
      end
   end

   // Array is never cleared; reset only blocks a store in the reset cycle.
   always_ff @(posedge clk) begin
      if (rst && dm_store && !dm_oor) begin
         mem[dm_idx] <= DM_in;
      end
   end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed test-plan steps then random traffic, all checked against a word-map model.
module tb_cpu_mem_responder;
   localparam int DEPTH = 16384;
   localparam int AW    = $clog2(DEPTH);

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        IM_enable  = 1'b0;
   logic [31:0] IM_address = '0;
   logic [31:0] IM_out;
   logic        DM_enable  = 1'b0;
   logic        DM_write   = 1'b0;
   logic [31:0] DM_address = '0;
   logic [31:0] DM_in      = '0;
   logic [31:0] DM_out;
   logic [31:0] rd_count;
   logic [31:0] wr_count;
   logic        oor_err;

   cpu_mem_responder #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .IM_enable(IM_enable), .IM_address(IM_address), .IM_out(IM_out),
      .DM_enable(DM_enable), .DM_write(DM_write), .DM_address(DM_address),
      .DM_in(DM_in), .DM_out(DM_out),
      .rd_count(rd_count), .wr_count(wr_count), .oor_err(oor_err)
   );

   // scoreboard / reference model
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] mem_m [int];
   logic [31:0] exp_q [$];
   logic [31:0] exp_im = '0, exp_dm = '0, exp_rd = '0, exp_wr = '0;
   logic        exp_oor = 1'b0;
   bit          im_known = 0, dm_known = 0;

   function automatic int word_of(logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   function automatic bit oor_of(logic [31:0] a);
`ifdef MEM_OOR_CHECK_EN
      return (a >> 2) >= DEPTH;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: advance the model from the current inputs, clock the DUT, compare.
   task automatic cycle();
      int wi, wd;
      wi = word_of(IM_address);
      wd = word_of(DM_address);
      if (!rst) begin
         exp_im = '0; exp_dm = '0; exp_rd = '0; exp_wr = '0; exp_oor = 1'b0;
         im_known = 1; dm_known = 1;
      end else begin
         if (IM_enable) begin
            exp_rd++;
            if (oor_of(IM_address)) begin
               exp_im = '0; im_known = 1; exp_oor = 1'b1;
            end else if (mem_m.exists(wi)) begin
               exp_im = mem_m[wi]; im_known = 1;
            end else begin
               im_known = 0;
            end
         end
         if (DM_enable && DM_write) begin
            exp_wr++;
            exp_dm = DM_in; dm_known = 1;
            if (oor_of(DM_address)) exp_oor = 1'b1;
            else mem_m[wd] = DM_in;
         end else if (DM_enable) begin
            exp_rd++;
            if (oor_of(DM_address)) begin
               exp_dm = '0; dm_known = 1; exp_oor = 1'b1;
            end else if (mem_m.exists(wd)) begin
               exp_dm = mem_m[wd]; dm_known = 1;
            end else begin
               dm_known = 0;
            end
         end
      end
      if (dm_known) exp_q.push_back(exp_dm);
      @(posedge clk);
      #1;
      chk("rd_count", rd_count, exp_rd);
      chk("wr_count", wr_count, exp_wr);
      chk("oor_err", {31'b0, oor_err}, {31'b0, exp_oor});
      if (im_known) chk("im_out", IM_out, exp_im);
      if (exp_q.size() > 0) chk("dm_out", DM_out, exp_q.pop_front());
   endtask

   // driver
   task automatic drive(logic ie, logic [31:0] ia, logic de, logic dw,
                        logic [31:0] da, logic [31:0] di);
      IM_enable = ie; IM_address = ia;
      DM_enable = de; DM_write = dw; DM_address = da; DM_in = di;
      cycle();
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = {26'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 4'b0} >> 4;
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(AW + 2, 31));
      return a;
   endfunction

   initial begin
      // reset state
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;

      // reset blocks a pending store
      drive(0, 0, 1, 1, 32'h200, 32'hCAFEF00D);
      rst = 1'b0;
      drive(1, 32'h200, 1, 1, 32'h200, 32'h00000055);
      chk("reset_im", IM_out, 32'h0);
      chk("reset_dm", DM_out, 32'h0);
      chk("reset_wr", wr_count, 32'h0);
      rst = 1'b1;
      drive(0, 0, 1, 0, 32'h200, 0);
      chk("reset_no_store", DM_out, 32'hCAFEF00D);

      // store then misaligned load
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      drive(0, 0, 1, 1, 32'h100, 32'hDEADBEEF);
      drive(0, 0, 1, 0, 32'h103, 0);
      chk("store_load", DM_out, 32'hDEADBEEF);
      chk("store_load_wr", wr_count, 32'd1);
      chk("store_load_rd", rd_count, 32'd1);

      // cross-port collision
      drive(0, 0, 1, 1, 32'h40, 32'h11111111);
      drive(1, 32'h40, 1, 1, 32'h40, 32'h22222222);
      chk("collision_old", IM_out, 32'h11111111);
      drive(1, 32'h40, 0, 0, 0, 0);
      chk("collision_new", IM_out, 32'h22222222);

      // hold
      drive(0, 0, 1, 1, 32'h80, 32'hA5A5A5A5);
      drive(0, 0, 1, 0, 32'h80, 0);
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, 0, 1, 32'h84, 32'hFFFFFFFF);
         chk("hold_dm", DM_out, 32'hA5A5A5A5);
      end

      // dual read
      drive(1, 32'h100, 1, 0, 32'h40, 0);
      chk("dual_rd", rd_count, 32'd6);
      chk("dual_im", IM_out, 32'hDEADBEEF);
      chk("dual_dm", DM_out, 32'h22222222);

      // out of range
      drive(0, 0, 1, 1, 32'h0, 32'h0BADC0DE);
      drive(0, 0, 1, 1, 32'h00010000, 32'h12345678);
      drive(0, 0, 1, 0, 32'h0, 0);
`ifdef MEM_OOR_CHECK_EN
      chk("oor_word0", DM_out, 32'h0BADC0DE);
      chk("oor_flag", {31'b0, oor_err}, 32'd1);
      drive(1, 32'h00020000, 0, 0, 0, 0);
      chk("oor_read_zero", IM_out, 32'h0);
      drive(0, 0, 0, 0, 0, 0);
      chk("oor_sticky", {31'b0, oor_err}, 32'd1);
`else
      chk("wrap_word0", DM_out, 32'h12345678);
      chk("wrap_flag", {31'b0, oor_err}, 32'd0);
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) != 0);
         drive($urandom_range(0, 1), rand_addr(), $urandom_range(0, 1),
               $urandom_range(0, 1), rand_addr(), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Responder side of the CPU's instruction and data memory ports: a single word-organised memory that serves instruction fetches (IM_*) and data loads/stores (DM_*) issued by the core. It sits beside `top`, taking the core's address, enable and write outputs and returning registered IM_out/DM_out one clock later. It also keeps simple access counters for bench and debug use. It is the memory model used for simulation and the synthesis stub for on-chip SRAM.

## Interface
- DEPTH, 16384 — memory size in 32-bit words; power of two.
- AW, $clog2(DEPTH) — word-index width; derived, not overridden.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-low.
- IM_enable  input  1  instruction read request.
- IM_address  input  32  instruction byte address.
- IM_out  output  32  instruction read data, registered.
- DM_enable  input  1  data access request.
- DM_write  input  1  1 = store, 0 = load; qualified by DM_enable.
- DM_address  input  32  data byte address.
- DM_in  input  32  store data.
- DM_out  output  32  data read data, registered.
- rd_count  output  32  enabled reads completed (IM + DM loads).
- wr_count  output  32  enabled DM stores completed.
- oor_err  output  1  sticky out-of-range flag (see Configuration).

## Operation
- Word index = address[AW+1:2]; address[1:0] ignored, so misaligned accesses hit the containing word.
- IM read: IM_enable=1 at edge → IM_out loads mem[index].
- DM load: DM_enable=1, DM_write=0 → DM_out loads mem[index].
- DM store: DM_enable=1, DM_write=1 → mem[index] ← DM_in, and DM_out loads DM_in (write-first on the DM port).
- Enable low: the corresponding output holds its last value; memory unchanged.
- DM_write with DM_enable=0: no effect.
- Same-cycle DM store and IM read of the same word: IM_out gets the OLD word (read-first across ports); the new word is visible to IM from the next fetch.
- Counters: rd_count += number of enabled reads this cycle (0, 1 or 2); wr_count += 1 per store. Both wrap modulo 2^32.
- Memory array is not cleared by reset; contents are undefined until written.

## Timing
- Read latency: 1 cycle. Data for the request sampled at edge N is on the output after edge N and stays stable until the next enabled access to that port.
- Store commits at the sampling edge; an enabled read of that word at edge N+1 returns the new data.
- Reset (rst=0 at an edge): IM_out=0, DM_out=0, rd_count=0, wr_count=0, oor_err=0. Reset takes priority: no store commits and no counter increments in a reset cycle, even if enables are high.
- Reset deasserted mid-stream: the first access is honoured at the first edge with rst=1. There is no residual output from pre-reset requests.
- No handshake: the responder is always ready, and every enabled request completes in exactly one cycle.

## Configuration
- MEM_OOR_CHECK_EN defined: an access counts as out of range when address[31:AW+2] ≠ 0.
  - Out-of-range reads return 0.
  - Out-of-range stores are dropped (memory unchanged; DM_out still loads DM_in).
  - Counters still increment.
  - oor_err sets on the edge that samples the access and stays 1 until reset.
- MEM_OOR_CHECK_EN undefined: upper address bits are ignored and addresses wrap modulo DEPTH words. oor_err is tied to 0.

## Test plan
- Reset: drive rst=0 with DM store requests active → after the edge, IM_out=DM_out=0, counters=0, and a later load of that word does not return the store data.
- Store/load: store 0xDEADBEEF at 0x100, then load 0x103 next cycle → DM_out=0xDEADBEEF one cycle after the load; wr_count=1, rd_count=1.
- Cross-port collision: word 0x40 holds 0x11111111. In one cycle, store 0x22222222 to 0x40 and IM fetch from 0x40 → IM_out=0x11111111; next fetch gives 0x22222222.
- Hold: one load returns 0xA5A5A5A5, then DM_enable=0 for 5 cycles → DM_out stays 0xA5A5A5A5; rd_count unchanged.
- Dual read: IM and DM loads in the same cycle → rd_count increments by 2.
- Out of range (DEPTH=16384): store 0x12345678 to 0x00010000, then load 0x00000000.
  - With MEM_OOR_CHECK_EN: word 0 is unchanged, oor_err=1 and stays 1.
  - Without it: load returns 0x12345678 and oor_err=0.
